// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      DONE,
      ERROR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_WIDTH    = 16;
   localparam int LANE_WIDTH     = 2;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs accepted stream bytes little-endian into a 32-bit word; o_word already
// includes the byte being loaded this cycle so the caller can latch it directly.
module byte_assembler
   import loader_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_clear,
   input  logic                        i_load,
   input  logic [7:0]                  i_byte,
   output logic [8*BYTES_PER_WORD-1:0] o_word,
   output logic                        o_word_full
);

   logic [LANE_WIDTH-1:0]       r_lane;
   logic [8*BYTES_PER_WORD-1:0] r_word;
   logic [8*BYTES_PER_WORD-1:0] w_word;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (i_load) begin
         r_word[{r_lane, 3'b000} +: 8] <= i_byte;
         r_lane                        <= r_lane + 1'b1;
      end
   end

   always_comb begin
      w_word = r_word;
      if (i_load) begin
         w_word[{r_lane, 3'b000} +: 8] = i_byte;
      end
   end

   assign o_word      = w_word;
   assign o_word_full = i_load && (r_lane == LANE_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a byte stream (16-bit word count header, then
// little-endian words) and holds the core in reset until the load completes.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam logic [COUNT_WIDTH:0] MAX_COUNT = (COUNT_WIDTH + 1)'(1) << ADDR_WIDTH;

   state_t                  r_state;
   logic [7:0]              r_count_lo;
   logic [COUNT_WIDTH-1:0]  r_count;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic                    r_cpu_reset;
   logic                    r_done;
   logic                    r_error;
   logic [ADDR_WIDTH:0]     r_words_loaded;

   logic                    w_accept;
   logic                    w_load;
   logic                    w_clear;
   logic [COUNT_WIDTH-1:0]  w_count;
   logic [ADDR_WIDTH:0]     w_wl_next;
   logic [DATA_WIDTH-1:0]   w_word;
   logic                    w_word_full;

   assign in_ready  = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
   assign w_accept  = in_valid && in_ready;
   assign w_load    = w_accept && (r_state == DATA);
   assign w_clear   = start && ((r_state == DONE) || (r_state == ERROR));
   assign w_count   = {in_data, r_count_lo};
   assign w_wl_next = r_words_loaded + 1'b1;

   byte_assembler u_asm (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_clear     (w_clear),
      .i_load      (w_load),
      .i_byte      (in_data),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= LEN_LO;
         r_count_lo     <= '0;
         r_count        <= '0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_cpu_reset    <= 1'b1;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            LEN_LO: begin
               if (w_accept) begin
                  r_count_lo <= in_data;
                  r_state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (w_accept) begin
                  r_count <= w_count;
                  if (w_count == '0) begin
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_cpu_reset <= 1'b0;
                  end else if ({1'b0, w_count} > MAX_COUNT) begin
                     r_state <= ERROR;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            // The 4th byte is merged combinationally so the word is complete here.
            DATA: begin
               if (w_word_full) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_words_loaded[ADDR_WIDTH-1:0];
                  r_wdata <= w_word;
                  r_state <= WRITE;
               end
            end
            WRITE: begin
               r_words_loaded <= w_wl_next;
               if (COUNT_WIDTH'(w_wl_next) == r_count) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_cpu_reset <= 1'b0;
               end else begin
                  r_state <= DATA;
               end
            end
            DONE: begin
               if (start) begin
                  r_state        <= LEN_LO;
                  r_done         <= 1'b0;
                  r_cpu_reset    <= 1'b1;
                  r_words_loaded <= '0;
               end
            end
            ERROR: begin
               if (start) begin
                  r_state        <= LEN_LO;
                  r_error        <= 1'b0;
                  r_words_loaded <= '0;
               end
            end
            default: r_state <= LEN_LO;
         endcase
      end
   end

   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign cpu_reset    = r_cpu_reset;
   assign done         = r_done;
   assign error        = r_error;
   assign words_loaded = r_words_loaded;

endmodule
